// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Multiplexes NREQ byte streams onto a single uart_tx. A requester that wins
// arbitration keeps the transmitter (packet lock) until it presents a byte
// flagged last or has sent MAX_BURST bytes. Without a lock, the winner is picked
// round-robin. Each byte walks IDLE -> SEND -> WAIT_BUSY -> WAIT_DONE so that
// exactly one act pulse is issued and the next byte waits for the uart.
module uart_tx_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_data,
    input  logic [NREQ-1:0]   i_req_last,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [NREQ-1:0]   o_grant,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_act,
    input  logic              i_tx_busy,
    output logic              o_busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_act_q, tx_act_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              lock_q, lock_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [NREQ-1:0]   win_onehot;
    logic [7:0]        win_byte;
    logic              win_last;
    logic              accept;
    logic [3:0]        cnt_next;
    int unsigned       cand;

    // Winner search: the lock owner alone, or first valid at/after ptr with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (lock_q) begin
            win_found = i_req_valid[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = 32'(ptr_q) + i;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                if (!win_found && i_req_valid[IDX_W'(cand)]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(cand);
                end
            end
        end
    end

    // Winner's byte, last flag and one-hot select
    always_comb begin
        win_byte   = '0;
        win_last   = 1'b0;
        win_onehot = NREQ'(1) << win_idx;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDX_W'(k) == win_idx) begin
                win_byte = i_req_data[8*k +: 8];
                win_last = i_req_last[k];
            end
        end
    end

    // Accept strobe: only in IDLE with the uart free and someone eligible
    always_comb begin
        accept      = (state_q == IDLE) && !i_tx_busy && win_found;
        o_req_ready = accept ? win_onehot : '0;
    end

    // Next-state, lock/burst bookkeeping and registered output values
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        lock_d    = lock_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        cnt_next  = cnt_q + 4'd1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SEND;
                    tx_data_d = win_byte;
                    grant_d   = win_onehot;
                    if (win_last || (cnt_next == 4'(MAX_BURST))) begin
                        // Release on this byte; grant stays visible until the byte is out
                        lock_d = 1'b0;
                        cnt_d  = '0;
                        ptr_d  = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    end else begin
                        lock_d  = 1'b1;
                        owner_d = win_idx;
                        cnt_d   = cnt_next;
                    end
                end
            end
            SEND: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = IDLE;
                    if (!lock_q) begin
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        tx_act_d = (state_d == SEND);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            tx_act_q  <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            lock_q    <= 1'b0;
            owner_q   <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_act_q  <= tx_act_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_tx_data = tx_data_q;
    assign o_tx_act  = tx_act_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 9-cycle uart busy model and
// per-requester byte queues; everything runs in one process.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ       = 4;
    localparam int unsigned MAX_BURST  = 4;
    localparam int          BUSY_CYC   = 9;
    localparam int          WAIT_LIMIT = 2000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_act;
    logic              tx_busy;
    logic              dut_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_grant     (grant),
        .o_tx_data   (tx_data),
        .o_tx_act    (tx_act),
        .i_tx_busy   (tx_busy),
        .o_busy      (dut_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] q3[$];
    int acc_log[$];

    int busy_cnt = 0;
    bit pend = 0;
    int cyc = 0;
    int last_acc = -1;
    int min_gap = 1000000;
    int viol_act = 0, viol_ready = 0, viol_multi = 0, viol_grant = 0;
    int act_total = 0, accept_total = 0;

    logic [NREQ-1:0] s_ready, s_grant;
    logic            s_act, s_busy;
    logic [7:0]      s_data;

    task automatic push_byte(input int k, input logic [7:0] d, input logic l);
        case (k)
            0: q0.push_back({l, d});
            1: q1.push_back({l, d});
            2: q2.push_back({l, d});
            default: q3.push_back({l, d});
        endcase
    endtask

    function automatic int qsz(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [8:0] qfront(input int k);
        case (k)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic pop_byte(input int k);
        case (k)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic drive_inputs();
        logic [8:0] v;
        for (int k = 0; k < NREQ; k++) begin
            if (qsz(k) > 0) begin
                v = qfront(k);
                req_valid[k]       = 1'b1;
                req_data[8*k +: 8] = v[7:0];
                req_last[k]        = v[8];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[8*k +: 8] = 8'h00;
                req_last[k]        = 1'b0;
            end
        end
    endtask

    task automatic clear_all();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        busy_cnt = 0;
        pend     = 0;
        tx_busy  = 1'b0;
        last_acc = -1;
        drive_inputs();
    endtask

    // One clock: sample mid-cycle, then update uart model and sources after the edge
    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        s_ready = req_ready;
        s_grant = grant;
        s_act   = tx_act;
        s_busy  = dut_busy;
        s_data  = tx_data;
        acc     = req_valid & req_ready;
        if ($countones(acc) > 1) viol_multi++;
        if (!$onehot0(grant)) viol_grant++;
        if (tx_act && tx_busy) viol_act++;
        if ((req_ready != '0) && dut_busy) viol_ready++;
        if (tx_act) begin
            act_total++;
            pend = 1;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k]) begin
                acc_log.push_back(k * 256 + int'(req_data[8*k +: 8]));
                accept_total++;
                if (last_acc >= 0 && (cyc - last_acc) < min_gap) min_gap = cyc - last_acc;
                last_acc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (busy_cnt > 0) busy_cnt--;
        if (pend) begin
            busy_cnt = BUSY_CYC;
            pend     = 0;
        end
        tx_busy = (busy_cnt > 0);
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k]) pop_byte(k);
        end
        drive_inputs();
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            tick();
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && q3.size() == 0 && !dut_busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        @(posedge clk);
        #1;
        n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant); else n_pass++;
        n_checks++; if (tx_act !== 1'b0) $display("FAIL reset_act: got %b expected 0", tx_act); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", tx_data); else n_pass++;
        n_checks++; if (dut_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", dut_busy); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        logic [NREQ-1:0] r_ready[16];
        logic [NREQ-1:0] r_grant[16];
        logic            r_act[16];
        logic            r_busy[16];
        logic [7:0]      r_data[16];
        acc_log.delete();
        push_byte(0, 8'h41, 1'b1);
        drive_inputs();
        for (int i = 0; i < 16; i++) begin
            tick();
            r_ready[i] = s_ready;
            r_grant[i] = s_grant;
            r_act[i]   = s_act;
            r_busy[i]  = s_busy;
            r_data[i]  = s_data;
        end
        n_checks++; if (r_ready[0] !== 4'b0001) $display("FAIL single_ready0: got %b expected 0001", r_ready[0]); else n_pass++;
        n_checks++; if (r_ready[1] !== 4'b0000) $display("FAIL single_ready1: got %b expected 0000", r_ready[1]); else n_pass++;
        n_checks++; if (r_act[0] !== 1'b0) $display("FAIL single_act0: got %b expected 0", r_act[0]); else n_pass++;
        n_checks++; if (r_act[1] !== 1'b1) $display("FAIL single_act1: got %b expected 1", r_act[1]); else n_pass++;
        n_checks++; if (r_act[2] !== 1'b0) $display("FAIL single_act2: got %b expected 0", r_act[2]); else n_pass++;
        n_checks++; if (r_data[1] !== 8'h41) $display("FAIL single_data: got %h expected 41", r_data[1]); else n_pass++;
        n_checks++; if (r_grant[1] !== 4'b0001) $display("FAIL single_grant_send: got %b expected 0001", r_grant[1]); else n_pass++;
        n_checks++; if (r_grant[11] !== 4'b0001) $display("FAIL single_grant_busy: got %b expected 0001", r_grant[11]); else n_pass++;
        n_checks++; if (r_grant[12] !== 4'b0000) $display("FAIL single_grant_done: got %b expected 0000", r_grant[12]); else n_pass++;
        n_checks++; if (r_busy[11] !== 1'b1) $display("FAIL single_busy_wait: got %b expected 1", r_busy[11]); else n_pass++;
        n_checks++; if (r_busy[12] !== 1'b0) $display("FAIL single_busy_idle: got %b expected 0", r_busy[12]); else n_pass++;
        n_checks++; if (r_data[15] !== 8'h41) $display("FAIL single_data_hold: got %h expected 41", r_data[15]); else n_pass++;
        n_checks++; if (acc_log.size() !== 1) $display("FAIL single_count: got %0d expected 1", acc_log.size()); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_log[5] = '{'h010, 'h111, 'h212, 'h313, 'h014};
        int got;
        bit ok;
        apply_reset();
        acc_log.delete();
        push_byte(0, 8'h10, 1'b1);
        push_byte(1, 8'h11, 1'b1);
        push_byte(2, 8'h12, 1'b1);
        push_byte(3, 8'h13, 1'b1);
        push_byte(0, 8'h14, 1'b1);
        drive_inputs();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL rr_timeout: got %b expected 1", ok); else n_pass++;
        n_checks++; if (acc_log.size() !== 5) $display("FAIL rr_count: got %0d expected 5", acc_log.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            got = (i < acc_log.size()) ? acc_log[i] : -1;
            n_checks++; if (got !== exp_log[i]) $display("FAIL rr_order[%0d]: got %h expected %h", i, got, exp_log[i]); else n_pass++;
        end
    endtask

    task automatic test_packet_lock();
        int exp_log[6] = '{'h230, 'h231, 'h232, 'h140, 'h141, 'h142};
        int got;
        bit ok;
        acc_log.delete();
        push_byte(2, 8'h30, 1'b0);
        drive_inputs();
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc_log.size() >= 1) begin
                ok = 1;
                break;
            end
        end
        n_checks++; if (ok !== 1'b1) $display("FAIL lock_first_timeout: got %b expected 1", ok); else n_pass++;
        push_byte(1, 8'h40, 1'b1);
        push_byte(1, 8'h41, 1'b1);
        push_byte(1, 8'h42, 1'b1);
        drive_inputs();
        for (int i = 0; i < 40; i++) tick();
        n_checks++; if (acc_log.size() !== 1) $display("FAIL lock_owner_absent_count: got %0d expected 1", acc_log.size()); else n_pass++;
        n_checks++; if (grant !== 4'b0100) $display("FAIL lock_owner_grant: got %b expected 0100", grant); else n_pass++;
        n_checks++; if (dut_busy !== 1'b0) $display("FAIL lock_owner_idle: got %b expected 0", dut_busy); else n_pass++;
        push_byte(2, 8'h31, 1'b0);
        push_byte(2, 8'h32, 1'b1);
        drive_inputs();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL lock_timeout: got %b expected 1", ok); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            got = (i < acc_log.size()) ? acc_log[i] : -1;
            n_checks++; if (got !== exp_log[i]) $display("FAIL lock_order[%0d]: got %h expected %h", i, got, exp_log[i]); else n_pass++;
        end
        n_checks++; if (grant !== 4'b0000) $display("FAIL lock_grant_released: got %b expected 0000", grant); else n_pass++;
    endtask

    task automatic test_burst_limit();
        int exp_log[7] = '{'h150, 'h151, 'h152, 'h153, 'h360, 'h154, 'h155};
        int got;
        bit ok;
        apply_reset();
        acc_log.delete();
        for (int i = 0; i < 6; i++) push_byte(1, 8'h50 + 8'(i), 1'b0);
        push_byte(3, 8'h60, 1'b1);
        drive_inputs();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL burst_timeout: got %b expected 1", ok); else n_pass++;
        n_checks++; if (acc_log.size() !== 7) $display("FAIL burst_count: got %0d expected 7", acc_log.size()); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            got = (i < acc_log.size()) ? acc_log[i] : -1;
            n_checks++; if (got !== exp_log[i]) $display("FAIL burst_order[%0d]: got %h expected %h", i, got, exp_log[i]); else n_pass++;
        end
        n_checks++; if (grant !== 4'b0010) $display("FAIL burst_lock_held: got %b expected 0010", grant); else n_pass++;
    endtask

    task automatic test_reset_mid_transfer();
        int exp_log[3] = '{'h377, 'h07A, 'h279};
        int got;
        bit ok;
        push_byte(1, 8'h70, 1'b1);
        drive_inputs();
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_busy) begin
                ok = 1;
                break;
            end
        end
        tick();
        n_checks++; if (ok !== 1'b1) $display("FAIL midrst_busy_timeout: got %b expected 1", ok); else n_pass++;
        n_checks++; if (dut_busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b expected 1", dut_busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (grant !== 4'b0000) $display("FAIL midrst_grant: got %b expected 0000", grant); else n_pass++;
        n_checks++; if (tx_act !== 1'b0) $display("FAIL midrst_act: got %b expected 0", tx_act); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL midrst_data: got %h expected 00", tx_data); else n_pass++;
        n_checks++; if (dut_busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", dut_busy); else n_pass++;
        clear_all();
        acc_log.delete();
        tick();
        tick();
        rst_n = 1'b1;
        push_byte(3, 8'h77, 1'b1);
        drive_inputs();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL midrst_timeout1: got %b expected 1", ok); else n_pass++;
        n_checks++; if (acc_log.size() !== 1) $display("FAIL midrst_no_retry: got %0d expected 1", acc_log.size()); else n_pass++;
        push_byte(2, 8'h79, 1'b1);
        push_byte(0, 8'h7A, 1'b1);
        drive_inputs();
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL midrst_timeout2: got %b expected 1", ok); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            got = (i < acc_log.size()) ? acc_log[i] : -1;
            n_checks++; if (got !== exp_log[i]) $display("FAIL midrst_order[%0d]: got %h expected %h", i, got, exp_log[i]); else n_pass++;
        end
    endtask

    task automatic test_busy_model();
        n_checks++; if (viol_act !== 0) $display("FAIL act_while_busy: got %0d expected 0", viol_act); else n_pass++;
        n_checks++; if (viol_ready !== 0) $display("FAIL ready_while_busy: got %0d expected 0", viol_ready); else n_pass++;
        n_checks++; if (viol_multi !== 0) $display("FAIL multi_ready: got %0d expected 0", viol_multi); else n_pass++;
        n_checks++; if (viol_grant !== 0) $display("FAIL grant_onehot: got %0d expected 0", viol_grant); else n_pass++;
        n_checks++; if (act_total !== accept_total) $display("FAIL act_per_byte: got %0d expected %0d", act_total, accept_total); else n_pass++;
        n_checks++; if (accept_total !== 23) $display("FAIL accept_total: got %0d expected 23", accept_total); else n_pass++;
        n_checks++; if (min_gap !== 12) $display("FAIL byte_period: got %0d expected 12", min_gap); else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_burst_limit();
        test_reset_mid_transfer();
        test_busy_model();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
